// File: rtl/wb_pwm_matrix.sv
// Wishbone-slave LED matrix PWM controller: CPU-written frame store, scanned plane by plane with BRIGHT_W-bit PWM.
// Bus ack is registered (one clock after strobe, one clock wide); scan outputs are registered from next-state values.
module wb_pwm_matrix #(
  parameter int NUM_PLANES   = 5,
  parameter int NUM_COLS     = 8,
  parameter int BRIGHT_W     = 8,
  parameter int ADR_W        = 6,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  output logic                  wb_ack_o,
  output logic [NUM_COLS-1:0]   col_data,
  output logic [NUM_PLANES-1:0] plane_sel,
  output logic                  frame_tick
);

  localparam int NUM_PIX = NUM_PLANES * NUM_COLS;
  localparam int PW      = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam int BW      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SCAN} state_t;

  logic [BRIGHT_W-1:0] mem [NUM_PIX];
  logic                enable;
  logic [7:0]          presc;
  logic [15:0]         frame_cnt;

  logic [ADR_W:0]      word_adr;
  logic                is_reg;
  logic [ADR_W-1:0]    pix_idx;
  logic                pix_ok;
  logic                access;
  logic                wr;
  logic [31:0]         byte_mask;
  logic [BRIGHT_W-1:0] lane_mask;
  logic [31:0]         rd_dat;
  logic                unused_bits;

  state_t              state, state_n;
  logic [PW-1:0]       plane, plane_n;
  logic [BW-1:0]       blank_cnt, blank_cnt_n;
  logic [7:0]          tick_cnt, tick_cnt_n;
  logic [7:0]          presc_act, presc_act_n;
  logic [BRIGHT_W-1:0] pwm_cnt, pwm_cnt_n;
  logic                frame_wrap;
  logic [NUM_COLS-1:0]   col_n;
  logic [NUM_PLANES-1:0] sel_n;
  logic [ADR_W-1:0]      scan_idx;

  assign word_adr  = wb_adr_i[ADR_W+2:2];
  assign is_reg    = word_adr[ADR_W];
  assign pix_idx   = word_adr[ADR_W-1:0];
  assign pix_ok    = int'(pix_idx) < NUM_PIX;
  // The !wb_ack_o term forces a dead clock between accesses under a held strobe.
  assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = access & wb_we_i & (|wb_sel_i);
  assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign lane_mask = byte_mask[BRIGHT_W-1:0];
  assign unused_bits = ^{wb_adr_i[31:ADR_W+3], wb_adr_i[1:0], wb_dat_i, byte_mask};

  always_comb begin
    rd_dat = '0;
    if (is_reg) begin
      if (word_adr[0]) rd_dat = {frame_cnt, 8'd0, 4'(plane), 3'd0, state != IDLE};
      else             rd_dat = {16'd0, presc, 7'd0, enable};
    end else if (pix_ok) begin
      rd_dat = 32'(mem[pix_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIX; i++) mem[i] <= '0;
      enable   <= 1'b0;
      presc    <= 8'd0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= (access && !wb_we_i) ? rd_dat : 32'd0;
      if (wr) begin
        if (!is_reg) begin
          if (pix_ok) mem[pix_idx] <= (mem[pix_idx] & ~lane_mask) | (wb_dat_i[BRIGHT_W-1:0] & lane_mask);
        end else if (!word_adr[0]) begin
          if (wb_sel_i[0]) enable <= wb_dat_i[0];
          if (wb_sel_i[1]) presc  <= wb_dat_i[15:8];
        end
      end
    end
  end

  always_comb begin
    state_n     = state;
    plane_n     = plane;
    blank_cnt_n = blank_cnt;
    tick_cnt_n  = tick_cnt;
    presc_act_n = presc_act;
    pwm_cnt_n   = pwm_cnt;
    frame_wrap  = 1'b0;
    if (!enable) begin
      state_n     = IDLE;
      plane_n     = '0;
      blank_cnt_n = '0;
      tick_cnt_n  = '0;
      presc_act_n = '0;
      pwm_cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n     = BLANK;
          plane_n     = '0;
          blank_cnt_n = '0;
        end
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state_n     = SCAN;
            blank_cnt_n = '0;
            tick_cnt_n  = '0;
            pwm_cnt_n   = '0;
            presc_act_n = presc;
          end else begin
            blank_cnt_n = blank_cnt + 1'b1;
          end
        end
        SCAN: begin
          // presc is only sampled on reload, so a CTRL write never truncates a tick in flight.
          if (tick_cnt == presc_act) begin
            tick_cnt_n  = '0;
            presc_act_n = presc;
            pwm_cnt_n   = pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
              state_n     = BLANK;
              blank_cnt_n = '0;
              if (plane == PW'(NUM_PLANES - 1)) begin
                plane_n    = '0;
                frame_wrap = 1'b1;
              end else begin
                plane_n = plane + 1'b1;
              end
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are computed from next-state values so they switch on the same edge as the FSM.
  always_comb begin
    col_n    = '0;
    sel_n    = '0;
    scan_idx = '0;
    if (state_n == SCAN) begin
      sel_n[plane_n] = 1'b1;
      for (int c = 0; c < NUM_COLS; c++) begin
        scan_idx = ADR_W'(plane_n) * ADR_W'(NUM_COLS) + ADR_W'(c);
        col_n[c] = pwm_cnt_n < mem[scan_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      plane      <= '0;
      blank_cnt  <= '0;
      tick_cnt   <= '0;
      presc_act  <= '0;
      pwm_cnt    <= '0;
      frame_cnt  <= 16'd0;
      col_data   <= '0;
      plane_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      plane      <= plane_n;
      blank_cnt  <= blank_cnt_n;
      tick_cnt   <= tick_cnt_n;
      presc_act  <= presc_act_n;
      pwm_cnt    <= pwm_cnt_n;
      col_data   <= col_n;
      plane_sel  <= sel_n;
      frame_tick <= frame_wrap;
      if (frame_wrap) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_pwm_matrix.sv
// Self-checking bench for wb_pwm_matrix: bus read-back, ack timing, PWM duty, frame sequencing, disable/reset.
module tb_wb_pwm_matrix;
  localparam int NP = 5;
  localparam int NC = 8;
  localparam logic [31:0] CTRL_A = 32'h100;
  localparam logic [31:0] STAT_A = 32'h104;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   wb_adr, wb_dat, wb_dat_o;
  logic [3:0]    wb_sel;
  logic          wb_cyc, wb_stb, wb_we, wb_ack_o;
  logic [NC-1:0] col_data;
  logic [NP-1:0] plane_sel;
  logic          frame_tick;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_pwm_matrix #(.NUM_PLANES(NP), .NUM_COLS(NC), .BRIGHT_W(8), .ADR_W(6), .BLANK_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_ack_o(wb_ack_o),
    .col_data(col_data), .plane_sel(plane_sel), .frame_tick(frame_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access; returns read data, clocks to ack, and ack level one clock after the ack.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     output logic [31:0] rdat, output int lat, output logic ack_after);
    lat = 0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    do begin
      step();
      lat++;
    end while (!wb_ack_o && lat < 8);
    rdat = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
    ack_after = wb_ack_o;
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() != 0) return exp_q.pop_front();
    return 32'hDEAD_BEEF;
  endfunction

  task automatic test_reset();
    logic [31:0] rd, e;
    int lat, n;
    logic aa;
    bus(1'b1, 32'h0, 32'h55, 4'hF, rd, lat, aa);
    bus(1'b1, CTRL_A, 32'h1, 4'hF, rd, lat, aa);
    n = 0;
    while (plane_sel == '0 && n < 100) begin step(); n++; end
    n_checks++;
    if (col_data[0] !== 1'b1) $display("FAIL reset_prescan col_data=%b exp bit0=1", col_data); else n_pass++;
    reset = 1'b1;
    step();
    n_checks++;
    if ({col_data, plane_sel, frame_tick, wb_ack_o, wb_dat_o} !== '0)
      $display("FAIL reset_outputs col=%b sel=%b tick=%b ack=%b dat=%h exp all 0", col_data, plane_sel, frame_tick, wb_ack_o, wb_dat_o);
    else n_pass++;
    step(); step();
    reset = 1'b0;
    exp_q.push_back(32'h0);
    bus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL reset_status got=%h exp=%h", rd, e); else n_pass++;
    exp_q.push_back(32'h0);
    bus(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL reset_mem0 got=%h exp=%h", rd, e); else n_pass++;
    exp_q.push_back(32'h0);
    bus(1'b0, CTRL_A, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL reset_ctrl got=%h exp=%h", rd, e); else n_pass++;
  endtask

  task automatic test_readback();
    logic [31:0] rd, e;
    int lat;
    logic aa;
    int idx[4]  = '{0, 7, 8, 39};
    logic [31:0] val[4] = '{32'h01, 32'h80, 32'hFF, 32'h3C};
    bus(1'b1, 32'd48, 32'hFFFF_FFA5, 4'hF, rd, lat, aa);
    n_checks++;
    if (lat !== 1 || aa !== 1'b0) $display("FAIL wr_ack_timing lat=%0d ack_after=%b exp lat=1 ack_after=0", lat, aa); else n_pass++;
    exp_q.push_back(32'h0000_00A5);
    bus(1'b0, 32'd48, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL read_idx12 got=%h exp=%h", rd, e); else n_pass++;
    n_checks++;
    if (lat !== 1 || aa !== 1'b0 || wb_dat_o !== 32'h0)
      $display("FAIL rd_ack_timing lat=%0d ack_after=%b dat_after=%h exp 1/0/0", lat, aa, wb_dat_o);
    else n_pass++;
    bus(1'b1, 32'd180, 32'h77, 4'hF, rd, lat, aa);
    n_checks++;
    if (lat !== 1) $display("FAIL oor_write_ack lat=%0d exp=1", lat); else n_pass++;
    exp_q.push_back(32'h0);
    bus(1'b0, 32'd180, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL read_idx45 got=%h exp=%h", rd, e); else n_pass++;
    bus(1'b1, 32'd48, 32'h11, 4'h0, rd, lat, aa);
    exp_q.push_back(32'h0000_00A5);
    bus(1'b0, 32'd48, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL sel0_noop got=%h exp=%h", rd, e); else n_pass++;
    for (int i = 0; i < 4; i++) bus(1'b1, 32'(idx[i] * 4), val[i], 4'hF, rd, lat, aa);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(val[i]);
      bus(1'b0, 32'(idx[i] * 4), 32'h0, 4'hF, rd, lat, aa);
      e = pop_exp(); n_checks++;
      if (rd !== e) $display("FAIL read_table idx=%0d got=%h exp=%h", idx[i], rd, e); else n_pass++;
    end
    bus(1'b1, CTRL_A, 32'hFFFF_FF00, 4'hF, rd, lat, aa);
    exp_q.push_back(32'h0000_FF00);
    bus(1'b0, CTRL_A, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL ctrl_readback got=%h exp=%h", rd, e); else n_pass++;
    bus(1'b1, CTRL_A, 32'h0, 4'hF, rd, lat, aa);
    bus(1'b1, STAT_A, 32'hFFFF_FFFF, 4'hF, rd, lat, aa);
    exp_q.push_back(32'h0);
    bus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL status_ro got=%h exp=%h", rd, e); else n_pass++;
  endtask

  task automatic test_held_strobe();
    int acks = 0, run = 0, maxrun = 0;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_00A5);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'd48; wb_sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_ack_o) begin
        acks++; run++;
        e = pop_exp(); n_checks++;
        if (wb_dat_o !== e) $display("FAIL held_data ack=%0d got=%h exp=%h", acks, wb_dat_o, e); else n_pass++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    exp_q.delete();
    n_checks++;
    if (acks !== 3) $display("FAIL held_ack_count got=%0d exp=3", acks); else n_pass++;
    n_checks++;
    if (maxrun !== 1) $display("FAIL held_ack_width got=%0d exp=1", maxrun); else n_pass++;
    step();
  endtask

  task automatic test_duty();
    logic [31:0] rd, e;
    int lat, n, hi, hi_first;
    logic aa;
    bus(1'b1, 32'd12, 32'd64, 4'hF, rd, lat, aa);
    bus(1'b1, 32'd32, 32'd255, 4'hF, rd, lat, aa);
    exp_q.push_back(32'd256); exp_q.push_back(32'd64); exp_q.push_back(32'd64);
    exp_q.push_back(32'd4);   exp_q.push_back(32'd256); exp_q.push_back(32'd255);
    bus(1'b1, CTRL_A, 32'h1, 4'hF, rd, lat, aa);
    n = 0;
    while (plane_sel == '0 && n < 100) begin step(); n++; end
    n_checks++;
    if (plane_sel !== 5'b00001) $display("FAIL duty_first_plane got=%b exp=00001", plane_sel); else n_pass++;
    n = 0; hi = 0; hi_first = 0;
    while (plane_sel == 5'b00001 && n < 2000) begin
      if (col_data[3]) begin hi++; if (n < 64) hi_first++; end
      n++; step();
    end
    e = pop_exp(); n_checks++;
    if (n !== int'(e)) $display("FAIL duty_window got=%0d exp=%0d", n, e); else n_pass++;
    e = pop_exp(); n_checks++;
    if (hi !== int'(e)) $display("FAIL duty_col3_high got=%0d exp=%0d", hi, e); else n_pass++;
    e = pop_exp(); n_checks++;
    if (hi_first !== int'(e)) $display("FAIL duty_col3_leading got=%0d exp=%0d", hi_first, e); else n_pass++;
    n = 0;
    while (plane_sel == '0 && n < 100) begin
      if (col_data !== '0) hi++;
      n++; step();
    end
    e = pop_exp(); n_checks++;
    if (n !== int'(e)) $display("FAIL duty_blank got=%0d exp=%0d", n, e); else n_pass++;
    n_checks++;
    if (plane_sel !== 5'b00010) $display("FAIL duty_second_plane got=%b exp=00010", plane_sel); else n_pass++;
    n = 0; hi = 0;
    while (plane_sel == 5'b00010 && n < 2000) begin
      if (col_data[0]) hi++;
      n++; step();
    end
    e = pop_exp(); n_checks++;
    if (n !== int'(e)) $display("FAIL duty_window2 got=%0d exp=%0d", n, e); else n_pass++;
    e = pop_exp(); n_checks++;
    if (hi !== int'(e)) $display("FAIL duty_full_bright got=%0d exp=%0d", hi, e); else n_pass++;
    bus(1'b1, CTRL_A, 32'h0, 4'hF, rd, lat, aa);
  endtask

  task automatic test_frame();
    logic [31:0] rd, e;
    int lat, n, g, t;
    logic aa;
    logic [NP-1:0] exp_sel;
    for (int p = 0; p < NP; p++) exp_q.push_back(32'(1 << p));
    bus(1'b1, CTRL_A, 32'h101, 4'hF, rd, lat, aa);
    n = 0;
    while (plane_sel == '0 && n < 100) begin step(); n++; end
    t = 0;
    for (int p = 0; p < NP; p++) begin
      e = pop_exp();
      exp_sel = e[NP-1:0];
      n_checks++;
      if (plane_sel !== exp_sel) $display("FAIL frame_plane p=%0d got=%b exp=%b", p, plane_sel, exp_sel); else n_pass++;
      n = 0;
      while (plane_sel == exp_sel && n < 3000) begin n++; t++; step(); end
      n_checks++;
      if (n !== 512) $display("FAIL frame_window p=%0d got=%0d exp=512", p, n); else n_pass++;
      if (p < NP - 1) begin
        g = 0;
        while (plane_sel == '0 && g < 100) begin g++; t++; step(); end
        n_checks++;
        if (g !== 4) $display("FAIL frame_gap p=%0d got=%0d exp=4", p, g); else n_pass++;
      end
    end
    // Measured from the first plane_sel rise, so the leading 4 blank clocks are excluded.
    n_checks++;
    if (frame_tick !== 1'b1 || t !== NP * (4 + 512) - 4)
      $display("FAIL frame_tick_time tick=%b t=%0d exp tick=1 t=%0d", frame_tick, t, NP * (4 + 512) - 4);
    else n_pass++;
    step();
    n_checks++;
    if (frame_tick !== 1'b0) $display("FAIL frame_tick_width got=%b exp=0", frame_tick); else n_pass++;
    exp_q.push_back(32'h0001_0001);
    bus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL frame_status got=%h exp=%h", rd, e); else n_pass++;
  endtask

  task automatic test_disable();
    logic [31:0] rd, e;
    int lat, n;
    logic aa;
    bus(1'b1, 32'd84, 32'd255, 4'hF, rd, lat, aa);
    n = 0;
    while (plane_sel !== 5'b00100 && n < 3000) begin step(); n++; end
    n_checks++;
    if (plane_sel !== 5'b00100 || col_data[5] !== 1'b1)
      $display("FAIL disable_pre sel=%b col=%b exp sel=00100 col5=1", plane_sel, col_data);
    else n_pass++;
    bus(1'b1, CTRL_A, 32'h100, 4'hF, rd, lat, aa);
    n_checks++;
    if (plane_sel !== '0 || col_data !== '0) $display("FAIL disable_outputs sel=%b col=%b exp 0", plane_sel, col_data); else n_pass++;
    exp_q.push_back(32'h0001_0000);
    bus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat, aa);
    e = pop_exp(); n_checks++;
    if (rd !== e) $display("FAIL disable_status got=%h exp=%h", rd, e); else n_pass++;
    bus(1'b1, CTRL_A, 32'h101, 4'hF, rd, lat, aa);
    n = 0;
    while (plane_sel == '0 && n < 100) begin n++; step(); end
    n_checks++;
    if (n !== 4 || plane_sel !== 5'b00001) $display("FAIL reenable dark=%0d sel=%b exp dark=4 sel=00001", n, plane_sel); else n_pass++;
    bus(1'b1, CTRL_A, 32'h0, 4'hF, rd, lat, aa);
  endtask

  initial begin
    reset = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0; wb_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    test_reset();
    test_readback();
    test_held_strobe();
    test_duty();
    test_frame();
    test_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
